// File: rtl/command_master.sv
// command_master: host-side initiator for the 16-bit GPU command bus.
// Sequences output enable, command strobe and data bus so the GPU captures a
// command word on the first strobe rising edge and a data word on the second,
// then for reads turns the bus around and samples the returned word.
// All outputs are registered from the next-state value, so every output
// reflects the state the block is in during that same cycle.
module command_master #(
  parameter int CLK_DIV   = 2,
  parameter int READ_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [15:0] reqCommand,
  input  logic [15:0] reqData,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        busCommandClk,
  output logic        busOutputEnable,
  output logic [15:0] busDataOut,
  output logic        busDataOe,
  input  logic [15:0] busDataIn
);

  localparam logic [7:0] DIV_C  = 8'(CLK_DIV);
  localparam logic [7:0] WAIT_C = 8'(READ_WAIT);

  typedef enum logic [3:0] {
    SYNC_HI,
    SYNC_LO,
    IDLE,
    CMD_LO,
    CMD_HI,
    DATA_LO,
    DATA_HI,
    DATA_HOLD,
    TURN,
    RD_WAIT,
    RD_END
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        strobe_q, strobe_d;
  logic        oe_q, oe_d;
  logic        drive_q, drive_d;
  logic [15:0] out_q, out_d;
  logic        write_q, write_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] data_q, data_d;

  logic accept;
  logic phase_done;
  logic wait_done;

  assign accept     = reqValid & ready_q;
  assign phase_done = (cnt_q == DIV_C);
  assign wait_done  = (cnt_q == WAIT_C);

  // Control state and registered bus outputs; reset forces the bus to a safe
  // idle (GPU owns nothing, strobe low) and arms the resync sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC_HI;
      cnt_q      <= 8'd0;
      ready_q    <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 16'h0000;
      strobe_q   <= 1'b0;
      oe_q       <= 1'b1;
      drive_q    <= 1'b0;
      out_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      strobe_q   <= strobe_d;
      oe_q       <= oe_d;
      drive_q    <= drive_d;
      out_q      <= out_d;
    end
  end

  // Latched request payload; only consumed after acceptance, so no reset.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    cmd_q   <= cmd_d;
    data_q  <= data_d;
  end

  // Next-state sequencing plus the bus pin values for the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    write_d    = write_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      SYNC_HI: begin
        if (phase_done) begin
          state_d = SYNC_LO;
          cnt_d   = 8'd1;
        end
      end
      SYNC_LO: begin
        if (phase_done) begin
          state_d = IDLE;
          cnt_d   = 8'd1;
        end
      end
      IDLE: begin
        if (accept) begin
          state_d = CMD_LO;
          cnt_d   = 8'd1;
          write_d = reqWrite;
          cmd_d   = reqCommand;
          data_d  = reqData;
        end
      end
      CMD_LO: begin
        if (phase_done) begin
          state_d = CMD_HI;
          cnt_d   = 8'd1;
        end
      end
      CMD_HI: begin
        if (phase_done) begin
          state_d = DATA_LO;
          cnt_d   = 8'd1;
        end
      end
      DATA_LO: begin
        if (phase_done) begin
          state_d = DATA_HI;
          cnt_d   = 8'd1;
        end
      end
      DATA_HI: begin
        if (phase_done) begin
          state_d = DATA_HOLD;
          cnt_d   = 8'd1;
        end
      end
      DATA_HOLD: begin
        if (phase_done) begin
          state_d = write_q ? IDLE : TURN;
          cnt_d   = 8'd1;
        end
      end
      TURN: begin
        state_d = RD_WAIT;
        cnt_d   = 8'd1;
      end
      RD_WAIT: begin
        if (wait_done) begin
          state_d    = RD_END;
          cnt_d      = 8'd1;
          rsp_data_d = busDataIn;
        end
      end
      RD_END: begin
        state_d = IDLE;
        cnt_d   = 8'd1;
      end
      default: begin
        state_d = SYNC_HI;
        cnt_d   = 8'd0;
      end
    endcase

    // Pin decode from the state being entered. Drive and output enable are
    // disjoint by construction, and TURN / RD_END / IDLE give the gap cycle.
    strobe_d  = (state_d == SYNC_HI) || (state_d == CMD_HI) || (state_d == DATA_HI);
    oe_d      = (state_d == SYNC_HI) || (state_d == SYNC_LO) || (state_d == RD_WAIT);
    drive_d   = (state_d == CMD_LO) || (state_d == CMD_HI) || (state_d == DATA_LO) ||
                (state_d == DATA_HI) || (state_d == DATA_HOLD);
    ready_d   = (state_d == IDLE);
    rsp_vld_d = (state_d == RD_END);

    // Bus value holds whenever nothing new is being presented.
    out_d = out_q;
    if ((state_d == CMD_LO) || (state_d == CMD_HI)) begin
      out_d = cmd_d;
    end else if ((state_d == DATA_LO) || (state_d == DATA_HI) || (state_d == DATA_HOLD)) begin
      out_d = data_d;
    end
  end

  assign reqReady        = ready_q;
  assign rspValid        = rsp_vld_q;
  assign rspData         = rsp_data_q;
  assign busCommandClk   = strobe_q;
  assign busOutputEnable = oe_q;
  assign busDataOe       = drive_q;
  assign busDataOut      = out_q;

endmodule

// File: tb/tb_command_master.sv
// Bench for command_master: three instances with different CLK_DIV/READ_WAIT,
// a small GPU command-interface model, table-driven transactions and a few
// hand-written sequences (reset values, back-to-back, reset mid-transaction).
module tb_command_master;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid   [N];
  logic        reqReady   [N];
  logic        reqWrite   [N];
  logic [15:0] reqCommand [N];
  logic [15:0] reqData    [N];
  logic        rspValid   [N];
  logic [15:0] rspData    [N];
  logic        strobe     [N];
  logic        oe         [N];
  logic [15:0] busOut     [N];
  logic        doe        [N];
  logic [15:0] busIn      [N];

  // GPU model state
  logic [15:0] gpuData [N];
  logic [15:0] gpuCmd  [N];
  logic [15:0] gpuDat  [N];
  logic        gpuPh   [N];
  logic        prevStb [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    command_master #(
      .CLK_DIV  (g == 0 ? 2 : (g == 1 ? 1 : 5)),
      .READ_WAIT(g == 0 ? 3 : (g == 1 ? 7 : 1))
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .reqValid       (reqValid[g]),
      .reqReady       (reqReady[g]),
      .reqWrite       (reqWrite[g]),
      .reqCommand     (reqCommand[g]),
      .reqData        (reqData[g]),
      .rspValid       (rspValid[g]),
      .rspData        (rspData[g]),
      .busCommandClk  (strobe[g]),
      .busOutputEnable(oe[g]),
      .busDataOut     (busOut[g]),
      .busDataOe      (doe[g]),
      .busDataIn      (busIn[g])
    );
    assign busIn[g] = oe[g] ? gpuData[g] : busOut[g];
  end

  // GPU interface model: strobe rising with OE high resyncs to command,
  // otherwise words alternate command / data.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (strobe[g] && !prevStb[g]) begin
        if (oe[g]) gpuPh[g] = 1'b0;
        else if (!gpuPh[g]) begin gpuCmd[g] = busIn[g]; gpuPh[g] = 1'b1; end
        else begin gpuDat[g] = busIn[g]; gpuPh[g] = 1'b0; end
      end
      prevStb[g] = strobe[g];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int s);
    int k;
    for (k = 0; k < 200 && !reqReady[s]; k++) step();
    check("ready_wait", {31'd0, reqReady[s]}, 32'd1);
  endtask

  typedef struct {
    int          s;
    logic        wr;
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] g;
    int          cmd_cyc;
    int          dat_cyc;
    int          oe_cyc;
    int          rv_cyc;
    int          rdy_cyc;
  } vec_t;

  vec_t vecs[8];

  // One transaction on instance s, checked against the vector's expectations.
  task automatic run_vec(input vec_t v);
    int s = v.s;
    int nrise = 0, cmd_rise = -1, dat_rise = -1, oe_rise = -1;
    int rv_cyc = -1, rv_cnt = 0, rdy = -1, viol = 0;
    logic [15:0] cmd_bus = 0, dat_bus = 0, rsp_at = 0;
    logic ps, poe, pdo;
    gpuData[s] = v.g;
    wait_ready(s);
    reqValid[s] = 1'b1; reqWrite[s] = v.wr; reqCommand[s] = v.c; reqData[s] = v.d;
    ps = strobe[s]; poe = oe[s]; pdo = doe[s];
    step();
    reqValid[s] = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (strobe[s] && !ps) begin
        nrise++;
        if (nrise == 1) begin cmd_rise = cyc; cmd_bus = busOut[s]; end
        else begin dat_rise = cyc; dat_bus = busOut[s]; end
      end
      if (oe[s] && !poe && oe_rise < 0) oe_rise = cyc;
      if (rspValid[s]) begin rv_cnt++; rv_cyc = cyc; rsp_at = rspData[s]; end
      if ((oe[s] && doe[s]) || (oe[s] && pdo) || (doe[s] && poe)) viol++;
      if (reqReady[s]) begin rdy = cyc; break; end
      ps = strobe[s]; poe = oe[s]; pdo = doe[s];
      step();
    end
    check("cmd_strobe_cyc", cmd_rise, v.cmd_cyc);
    check("cmd_bus", {16'd0, cmd_bus}, {16'd0, v.c});
    check("data_strobe_cyc", dat_rise, v.dat_cyc);
    check("data_bus", {16'd0, dat_bus}, {16'd0, v.d});
    check("strobe_count", nrise, 2);
    check("model_cmd", {16'd0, gpuCmd[s]}, {16'd0, v.c});
    check("model_data", {16'd0, gpuDat[s]}, {16'd0, v.d});
    check("bus_owner_gap", viol, 0);
    check("ready_cyc", rdy, v.rdy_cyc);
    check("oe_rise_cyc", oe_rise, v.oe_cyc);
    check("rsp_cyc", rv_cyc, v.rv_cyc);
    check("rsp_pulses", rv_cnt, v.wr ? 0 : 1);
    if (!v.wr) begin
      check("rsp_data", {16'd0, rsp_at}, {16'd0, v.g});
      step();
      check("rsp_hold", {16'd0, rspData[s]}, {16'd0, v.g});
      check("rsp_single", {31'd0, rspValid[s]}, 32'd0);
    end
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      reqValid[g] = 0; reqWrite[g] = 0; reqCommand[g] = 0; reqData[g] = 0;
      gpuData[g] = 0; gpuCmd[g] = 0; gpuDat[g] = 0; gpuPh[g] = 0; prevStb[g] = 0;
    end
    //          s  wr  cmd       data      gpu      cmd dat  oe  rv  rdy
    vecs[0] = '{0, 1, 16'h1234, 16'hABCD, 16'h0000, 3,  7,  -1, -1, 11};
    vecs[1] = '{0, 0, 16'h8001, 16'h0010, 16'h5A5A, 3,  7,  12, 15, 16};
    vecs[2] = '{0, 1, 16'h0000, 16'hFFFF, 16'h0000, 3,  7,  -1, -1, 11};
    vecs[3] = '{0, 0, 16'h7FFF, 16'h8000, 16'hA5A5, 3,  7,  12, 15, 16};
    vecs[4] = '{1, 1, 16'h00FF, 16'h0F0F, 16'h0000, 2,  4,  -1, -1, 6};
    vecs[5] = '{1, 0, 16'h4321, 16'h0001, 16'h1357, 2,  4,  7,  14, 15};
    vecs[6] = '{2, 1, 16'hC3C3, 16'h3C3C, 16'h0000, 6,  16, -1, -1, 26};
    vecs[7] = '{2, 0, 16'h0F0F, 16'hF0F0, 16'hFFFF, 6,  16, 27, 28, 29};

    // Reset values while reset is held
    reset = 1'b1;
    #1;
    check("rst_strobe", {31'd0, strobe[0]}, 32'd0);
    check("rst_oe", {31'd0, oe[0]}, 32'd1);
    check("rst_doe", {31'd0, doe[0]}, 32'd0);
    check("rst_ready", {31'd0, reqReady[0]}, 32'd0);
    check("rst_rspdata", {16'd0, rspData[0]}, 32'd0);
    #22;
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back: valid held across a write then a read on instance 0
    begin
      int rdy1 = -1, rdy2 = -1, rv_cyc = -1, rv_cnt = 0, nrise = 0, viol = 0;
      logic [15:0] mc = 0, md = 0, rsp_at = 0;
      logic acc_ok = 0, ps, poe, pdo;
      wait_ready(0);
      gpuData[0] = 16'h6C6C;
      reqValid[0] = 1; reqWrite[0] = 1; reqCommand[0] = 16'h1111; reqData[0] = 16'h2222;
      ps = strobe[0]; poe = oe[0]; pdo = doe[0];
      step();
      reqWrite[0] = 0; reqCommand[0] = 16'h9003; reqData[0] = 16'h0044;
      for (int cyc = 1; cyc < 100; cyc++) begin
        if (strobe[0] && !ps) nrise++;
        if ((oe[0] && doe[0]) || (oe[0] && pdo) || (doe[0] && poe)) viol++;
        if (rspValid[0]) begin rv_cnt++; rv_cyc = cyc; rsp_at = rspData[0]; end
        if (cyc == rdy1 + 1) begin
          acc_ok = !reqReady[0] && doe[0] && (busOut[0] == 16'h9003);
          reqValid[0] = 0;
        end
        if (reqReady[0] && rdy1 < 0) begin rdy1 = cyc; mc = gpuCmd[0]; md = gpuDat[0]; end
        else if (reqReady[0] && cyc > rdy1 + 1) begin rdy2 = cyc; break; end
        ps = strobe[0]; poe = oe[0]; pdo = doe[0];
        step();
      end
      check("b2b_first_ready", rdy1, 11);
      check("b2b_model_cmd1", {16'd0, mc}, 32'h1111);
      check("b2b_model_data1", {16'd0, md}, 32'h2222);
      check("b2b_second_accept", {31'd0, acc_ok}, 32'd1);
      check("b2b_rsp_cyc", rv_cyc, 26);
      check("b2b_rsp_pulses", rv_cnt, 1);
      check("b2b_rsp_data", {16'd0, rsp_at}, 32'h6C6C);
      check("b2b_model_cmd2", {16'd0, gpuCmd[0]}, 32'h9003);
      check("b2b_model_data2", {16'd0, gpuDat[0]}, 32'h0044);
      check("b2b_strobes", nrise, 4);
      check("b2b_owner_gap", viol, 0);
      check("b2b_second_ready", rdy2, 27);
    end

    // Reset during DATA_LO of a read on instance 0, then resync and a write
    begin
      int hi = 0, lo = 0, rv = 0, ok = 0;
      wait_ready(0);
      gpuData[0] = 16'h5A5A;
      reqValid[0] = 1; reqWrite[0] = 0; reqCommand[0] = 16'h8001; reqData[0] = 16'h0010;
      step();
      reqValid[0] = 0;
      for (int k = 1; k < 5; k++) step();
      check("mid_data_lo_bus", {16'd0, busOut[0]}, 32'h0010);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_strobe", {31'd0, strobe[0]}, 32'd0);
      check("mid_rst_oe", {31'd0, oe[0]}, 32'd1);
      check("mid_rst_doe", {31'd0, doe[0]}, 32'd0);
      check("mid_rst_out", {16'd0, busOut[0]}, 32'd0);
      check("mid_rst_ready", {31'd0, reqReady[0]}, 32'd0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 50; k++) begin
        step();
        if (rspValid[0]) rv++;
        if (strobe[0] && oe[0]) hi++;
        if (!strobe[0] && oe[0] && hi > 0) lo++;
        if (reqReady[0]) begin ok = 1; break; end
      end
      check("resync_ready", ok, 1);
      check("resync_hi_cycles", hi, 2);
      check("resync_lo_cycles", lo, 2);
      check("resync_no_rsp", rv, 0);
      run_vec('{0, 1, 16'h00FF, 16'h0F0F, 16'h0000, 3, 7, -1, -1, 11});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/command_master.md
# command_master

Host-side initiator for the 16-bit GPU command bus. It accepts write and read requests on a valid/ready port and sequences the bus pins (`busOutputEnable`, `busCommandClk`, data bus) so the GPU command interface captures a command word on the first `busCommandClk` rising edge and a data word on the second. For reads, it then releases the bus, asserts output enable and samples the GPU's returned word. It sits in the controller FPGA/MCU-bridge, between the host logic and the board-level tristate pads; the pads themselves are instantiated outside this block.

## Interface
Parameters:
- `CLK_DIV`, default 2: length of each bus phase, in `clk` cycles. Legal range 1..255.
- `READ_WAIT`, default 3: number of `clk` cycles output enable is held before the read sample. Legal range 1..255.

Ports:
- `clk`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `reqValid`  in  1: request present.
- `reqReady`  out  1: block can accept a request.
- `reqWrite`  in  1: 1 = write, 0 = read. Both types send command and data words.
- `reqCommand`  in  16: command word.
- `reqData`  in  16: data word (the address/argument for reads).
- `rspValid`  out  1: one-cycle pulse carrying read data.
- `rspData`  out  16: read data; holds its value until the next read.
- `busCommandClk`  out  1: bus strobe; the GPU samples on its rising edge.
- `busOutputEnable`  out  1: 1 = GPU drives the data bus.
- `busDataOut`  out  16: value to drive onto the data bus.
- `busDataOe`  out  1: pad drive enable for `busDataOut`.
- `busDataIn`  in  16: data bus as seen at the pads.

## Operation
- All outputs are registered.
- Reset values: `busCommandClk`=0, `busOutputEnable`=1, `busDataOe`=0, `busDataOut`=0, `reqReady`=0, `rspValid`=0, `rspData`=0, state=SYNC_HI.
- A phase counter (8 bits) counts `CLK_DIV` cycles in each timed state.
- Bus signals in each state:
  - SYNC_HI: OE=1, strobe=1, drive off. Lasts `CLK_DIV` cycles, then SYNC_LO.
  - SYNC_LO: OE=1, strobe=0. Lasts `CLK_DIV` cycles, then IDLE.
  - Purpose of SYNC: a strobe edge while OE is high forces the GPU interface back to expecting a command word.
- IDLE: `reqReady`=1, OE=0, drive off, strobe=0.
  - On `reqValid & reqReady`, latch `reqWrite`, `reqCommand` and `reqData`, drop `reqReady`, and go to CMD_LO.
- Write sequence (each state lasts `CLK_DIV` cycles):
  - CMD_LO: drive=1, out=command, strobe=0.
  - CMD_HI: strobe=1.
  - DATA_LO: out=data, strobe=0.
  - DATA_HI: strobe=1.
  - DATA_HOLD: strobe=0, data still driven.
  - Exit from DATA_HOLD: write → IDLE; read → TURN.
- Read sequence:
  - TURN (1 cycle): drive=0, OE=0.
  - RD_WAIT (`READ_WAIT` cycles): OE=1. On the last cycle, `busDataIn` is registered into `rspData`.
  - RD_END (1 cycle): `rspValid`=1, OE=0, drive=0. Then go to IDLE.
- Invariants:
  - `busDataOe` and `busOutputEnable` are never both 1.
  - At least one cycle with both at 0 separates any change of bus owner.
- `busDataOut` holds its last value when drive is off.
- `reqReady` is 1 only in IDLE, so there is no request queue.

## Timing
- Cycle 0 is the IDLE cycle where a request is accepted.
- Write:
  - Command strobe rises at cycle 1+`CLK_DIV`.
  - Data strobe rises at cycle 1+3·`CLK_DIV`.
  - Block is back in IDLE (`reqReady`=1) at cycle 1+5·`CLK_DIV`.
- Read:
  - `busOutputEnable` rises at cycle 2+5·`CLK_DIV`.
  - `rspValid` is high at cycle 2+5·`CLK_DIV`+`READ_WAIT`.
  - Back in IDLE one cycle later.
- Setup and hold: data is stable for `CLK_DIV` cycles before and after each strobe rising edge.
- Post-reset SYNC takes 2·`CLK_DIV` cycles before `reqReady` first rises.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately (asynchronously).
  - The latched request is discarded and no `rspValid` is produced.
  - The SYNC sequence reruns after release, which realigns the GPU side.
- `reqValid` asserted during SYNC or a busy state: ignored, and not lost by this block; the host must hold it until `reqReady`=1.

## Test plan
- Write, `CLK_DIV`=2, cmd 0x1234, data 0xABCD → strobe rises at cycles 3 and 7 with the bus at 0x1234 and 0xABCD. GPU interface model shows `commandToGpu`=0x1234 and `dataToGpu`=0xABCD. `reqReady` returns at cycle 11.
- Read, cmd 0x8001, data 0x0010, model `dataFromGpu`=0x5A5A, `READ_WAIT`=3 → `rspValid` is a single pulse at cycle 15 with `rspData`=0x5A5A. `rspData` still reads 0x5A5A afterwards.
- Back-to-back: `reqValid` held high for a write then a read → second request accepted on the first IDLE cycle after the write. No overlapping strobes; the model decodes both correctly.
- Reset during DATA_LO → all outputs take reset values in the same cycle, a SYNC pulse is seen with OE=1, and a subsequent write of 0x00FF/0x0F0F is decoded correctly by the model.
- Sweep `CLK_DIV`=1 and 5, `READ_WAIT`=1 and 7 with random traffic → latencies match the formulas. The invariant `busDataOe & busOutputEnable` is never 1, and a turnaround cycle is present on every ownership change.
